counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Sequencing controller for the lab up/down counter datapath. Turns user button pulses and switch settings into the counter's `enable1`/`enable2`/`reset`/`updown`/`freerun`/`divideby`/`halfmax` controls, and paces counting with a prescaled tick. It decides when a bounded run is finished by watching the counter's `count` feedback, and it flags an invalid `divideby` setting. It sits between the board I/O (debounced keys, switches) and the counter instance.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per count tick; legal range is 2 or more.
- `CNT_W`, 24: counter width.
- `DIV_W`, 6: width of `divideby`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high as decided.
- `start`  in  1  one-cycle pulse: latch switches and begin a run.
- `stop`  in  1  one-cycle pulse: abort the run and hold `count`.
- `clear`  in  1  one-cycle pulse: zero the counter and return to IDLE.
- `sw_divideby`  in  DIV_W  requested divide setting.
- `sw_updown`  in  1  1 = up, 0 = down.
- `sw_freerun`  in  1  1 = free-run, 0 = bounded run.
- `count`  in  CNT_W  counter value fed back from the datapath.
- `enable1`, `enable2`, `counter_reset`  out  1 each  counter controls.
- `updown`, `freerun`  out  1 each  latched mode bits.
- `divideby`  out  DIV_W  latched divide setting.
- `halfmax`  out  CNT_W  run bound.
- `done`  out  1  bounded run complete.
- `err`  out  1  invalid `divideby`.
- `state`  out  3  current FSM state, for debug.

## Operation
- States (encoding): IDLE=0, CLEAR=1, RUN=2, DONE=3, ERR=4.
- Latch on `start`, taken in IDLE or DONE:
  - `divideby`, `updown` and `freerun` are captured from the switches.
  - `halfmax` is set to `{CNT_W{1}} >> sw_divideby`.
  - If `sw_divideby == 0` or `sw_divideby >= CNT_W`, go to ERR. Otherwise set `go=1` and go to CLEAR.
- CLEAR (exactly one cycle):
  - `enable1=1`, `enable2=1`, `counter_reset=1`.
  - Prescaler is zeroed.
  - Next state is RUN if `go`, else IDLE; `go` is cleared on exit.
- RUN:
  - `enable1=1`.
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - `enable2=1` for one cycle when the prescaler equals TICK_DIV-1, unless the done condition holds in that cycle.
  - Done condition, bounded runs only (`freerun=0`): up uses `count >= halfmax`, down uses `count <= halfmax`. When it holds, go to DONE.
  - A free-run never completes; the counter wraps modulo 2^CNT_W.
- DONE: `enable1=0`, `enable2=0`, `done=1`. Latched outputs are held.
- ERR: `err=1`, `enable1=1`, `enable2=0` (the counter's zero-divide LED path is active). `start` and `stop` are ignored here; only `clear` exits.
- `stop` in RUN goes to IDLE with `count` held. In other states `stop` is ignored.
- `clear` in any state sets `go=0` and goes to CLEAR.
- Priority for simultaneous pulses: `clear` > `stop` > `start`.
- IDLE outputs: `enable1=0`, `enable2=0`, `counter_reset=0`. Latched mode outputs keep their last values.

## Timing
- All outputs are registered (Moore) and are valid in the cycle after the edge that enters a state.
- Reset values: state IDLE; all 1-bit outputs 0; `divideby=0`; `halfmax=0`; prescaler 0; `go=0`.
- `start` sampled at edge k gives CLEAR (`counter_reset=1`) in cycle k+1. The first `enable2` pulse comes TICK_DIV cycles after RUN is entered.
- The done check uses `count` as registered by the counter. With TICK_DIV >= 2, at most one tick is in flight, so the counter never overshoots `halfmax`.
- A bounded down-run starting from 0 reaches DONE in the first RUN cycle, because 0 <= `halfmax`.
- Reset asserted mid-run forces IDLE immediately. `enable2` drops asynchronously with it.

## Structure
- `counter_ctrl_pkg` holds:
  - the state encoding constants (ST_IDLE..ST_ERR);
  - `CNT_W_DEF=24`, `DIV_W_DEF=6`;
  - `MAX_COUNT = 24'hFF_FFFF`.
- Sub-module `tick_prescaler` (ports `clk`, `reset`, `clr`, `en`, `tick`) holds the TICK_DIV counter. The FSM and the mode/halfmax latches stay in `counter_ctrl`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset during RUN -> all outputs 0 and `state=0` immediately, without waiting for a clock edge.
- `sw_divideby=20`, up, bounded, `start` -> `halfmax=15`; `counter_reset` pulses once; 15 `enable2` pulses spaced 4 cycles apart; `done=1` when `count=15`; `enable1` then low.
- `sw_divideby=0`, `start` -> `err=1`, `enable1=1`, `enable2=0`, `state=4`. A further `start` is ignored. `clear` -> one CLEAR cycle, then IDLE with `err=0`.
- Free-run up with `divideby=1` -> `enable2` keeps pulsing every 4 cycles and `done` stays 0. `stop` -> IDLE with `enable1=0`.
- Bounded down, `divideby=20`, `start` -> CLEAR, then RUN for one cycle, then DONE. No `enable2` pulse is issued.
- `clear` and `start` in the same cycle while in DONE -> `clear` wins: CLEAR, then IDLE, and the latched `divideby` is unchanged.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the lab counter sequencing controller.
// Includes the state encoding, the default widths and the divide-setting legality check.
package counter_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 24;
  localparam int unsigned DIV_W_DEF = 6;
  localparam logic [CNT_W_DEF-1:0] MAX_COUNT = 24'hFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // A shift of zero or of the full width leaves no usable run bound.
  function automatic logic div_invalid(input int unsigned div, input int unsigned cnt_w);
    return (div == 0) || (div >= cnt_w);
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Board-side bundle between the key/switch front end and the counter controller.
// master drives the buttons, switches and count feedback; slave is the controller.
interface counter_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
);
  logic             start;
  logic             stop;
  logic             clear;
  logic [DIV_W-1:0] sw_divideby;
  logic             sw_updown;
  logic             sw_freerun;
  logic [CNT_W-1:0] count;

  logic             enable1;
  logic             enable2;
  logic             counter_reset;
  logic             updown;
  logic             freerun;
  logic [DIV_W-1:0] divideby;
  logic [CNT_W-1:0] halfmax;
  logic             done;
  logic             err;
  logic [2:0]       state;

  modport master (
    output start, stop, clear, sw_divideby, sw_updown, sw_freerun, count,
    input  enable1, enable2, counter_reset, updown, freerun, divideby,
           halfmax, done, err, state
  );

  modport slave (
    input  start, stop, clear, sw_divideby, sw_updown, sw_freerun, count,
    output enable1, enable2, counter_reset, updown, freerun, divideby,
           halfmax, done, err, state
  );

endinterface

// File: rtl/counter_ctrl_tick_prescaler.sv
// Divides the system clock down to the count tick; tick is high on the last
// prescaler cycle of each TICK_DIV period while enabled.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned    PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for the lab up/down counter: latches switch modes on start,
// paces counting with the prescaled tick and ends bounded runs from count feedback.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF
) (
  input logic           clk,
  input logic           reset,
  counter_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state_q, state_d;
  logic             go_q, go_d;
  logic             updown_q, updown_d;
  logic             freerun_q, freerun_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             en1_q, en1_d;
  logic             en2_q, en2_d;
  logic             crst_q, crst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic tick;
  logic run_finished;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == ST_CLEAR),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

  assign run_finished = !freerun_q &&
                        (updown_q ? (bus.count >= half_q) : (bus.count <= half_q));

  always_comb begin
    state_d   = state_q;
    go_d      = go_q;
    updown_d  = updown_q;
    freerun_d = freerun_q;
    div_d     = div_q;
    half_d    = half_q;

    if (bus.clear) begin
      state_d = ST_CLEAR;
      go_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            updown_d  = bus.sw_updown;
            freerun_d = bus.sw_freerun;
            div_d     = bus.sw_divideby;
            half_d    = ALL_ONES >> bus.sw_divideby;
            if (div_invalid(32'(bus.sw_divideby), CNT_W)) begin
              state_d = ST_ERR;
            end else begin
              go_d    = 1'b1;
              state_d = ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          state_d = go_q ? ST_RUN : ST_IDLE;
          go_d    = 1'b0;
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_IDLE;
          end else if (run_finished) begin
            state_d = ST_DONE;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register as Moore outputs.
    en1_d  = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_ERR);
    en2_d  = (state_d == ST_CLEAR) ||
             ((state_q == ST_RUN) && (state_d == ST_RUN) && tick);
    crst_d = (state_d == ST_CLEAR);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      go_q      <= 1'b0;
      updown_q  <= 1'b0;
      freerun_q <= 1'b0;
      div_q     <= '0;
      half_q    <= '0;
      en1_q     <= 1'b0;
      en2_q     <= 1'b0;
      crst_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      updown_q  <= updown_d;
      freerun_q <= freerun_d;
      div_q     <= div_d;
      half_q    <= half_d;
      en1_q     <= en1_d;
      en2_q     <= en2_d;
      crst_q    <= crst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.enable1       = en1_q;
  assign bus.enable2       = en2_q;
  assign bus.counter_reset = crst_q;
  assign bus.updown        = updown_q;
  assign bus.freerun       = freerun_q;
  assign bus.divideby      = div_q;
  assign bus.halfmax       = half_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a vector table, hand-written corner sequences and a random
// phase, all checked against a cycle-level reference model and an up/down counter stand-in.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int unsigned TD = 4;
  localparam int unsigned CW = 24;
  localparam int unsigned DW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] cnt_env;
  int            n_cmp = 0;
  int            n_bad = 0;

  counter_ctrl_if #(.CNT_W(CW), .DIV_W(DW)) bus ();

  counter_ctrl #(
    .TICK_DIV(TD),
    .CNT_W   (CW),
    .DIV_W   (DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the counter datapath that the controller drives.
  assign bus.count = cnt_env;
  always @(posedge clk or posedge reset) begin
    if (reset)                           cnt_env <= '0;
    else if (bus.counter_reset)          cnt_env <= '0;
    else if (bus.enable1 && bus.enable2) cnt_env <= bus.updown ? cnt_env + 1'b1 : cnt_env - 1'b1;
  end

  // Reference model: phase numbers follow the documented state codes; run progress is
  // tracked as elapsed RUN cycles rather than a prescaler register.
  int            m_phase, m_ridx;
  bit            m_go, m_up, m_fr;
  logic [DW-1:0] m_div;
  logic [CW-1:0] m_half;
  bit            e_en1, e_en2, e_rst;

  task automatic model_reset();
    m_phase = 0; m_ridx = 0; m_go = 0; m_up = 0; m_fr = 0;
    m_div = '0; m_half = '0; e_en1 = 0; e_en2 = 0; e_rst = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl,
                            input logic [DW-1:0] dv, input bit up, input bit fr,
                            input logic [CW-1:0] cnt);
    int nph;
    bit tk;
    bit fin;
    nph = m_phase;
    tk  = 0;
    fin = 0;
    if (cl) begin
      nph  = 1;
      m_go = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      if (st) begin
        m_div  = dv;
        m_up   = up;
        m_fr   = fr;
        m_half = MAX_COUNT >> dv;
        if (dv == 0 || dv >= CW) nph = 4;
        else begin nph = 1; m_go = 1; end
      end
    end else if (m_phase == 1) begin
      nph  = m_go ? 2 : 0;
      m_go = 0;
    end else if (m_phase == 2) begin
      fin = !m_fr && (m_up ? (cnt >= m_half) : (cnt <= m_half));
      tk  = (m_ridx % TD) == TD - 1;
      if (sp)       nph = 0;
      else if (fin) nph = 3;
    end
    e_en1   = (nph == 1) || (nph == 2) || (nph == 4);
    e_en2   = (nph == 1) || (m_phase == 2 && nph == 2 && tk);
    e_rst   = (nph == 1);
    m_ridx  = (m_phase == 2 && nph == 2) ? m_ridx + 1 : 0;
    m_phase = nph;
  endtask

  function automatic logic [39:0] exp_vec();
    return {3'(m_phase), e_en1, e_en2, e_rst, (m_phase == 3), (m_phase == 4),
            m_up, m_fr, m_div, m_half};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {bus.state, bus.enable1, bus.enable2, bus.counter_reset, bus.done, bus.err,
            bus.updown, bus.freerun, bus.divideby, bus.halfmax};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock: present inputs at a falling edge, predict, then check after the rise.
  task automatic cycle(input bit st, input bit sp, input bit cl,
                       input logic [DW-1:0] dv, input bit up, input bit fr);
    bus.start       = st;
    bus.stop        = sp;
    bus.clear       = cl;
    bus.sw_divideby = dv;
    bus.sw_updown   = up;
    bus.sw_freerun  = fr;
    model_step(st, sp, cl, dv, up, fr, bus.count);
    @(negedge clk);
    check("model", 64'(dut_vec()), 64'(exp_vec()));
  endtask

  typedef struct {
    bit            st, sp, cl;
    logic [DW-1:0] dv;
    bit            up, fr;
    logic [2:0]    e_state;
    logic [4:0]    e_ctl;   // {enable1, enable2, counter_reset, done, err}
    logic [DW-1:0] e_div;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit sp, input bit cl, input int dv,
                              input bit up, input bit fr, input int es, input logic [4:0] ec,
                              input int ed);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.dv = DW'(dv); v.up = up; v.fr = fr;
    v.e_state = 3'(es); v.e_ctl = ec; v.e_div = DW'(ed);
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    int pulses, gaps, last, first, n_rst, cyc;
    bit fin_seen, done_seen;
    logic [CW-1:0] held;

    tbl[0]  = mk(1,0,0, 0,1,0, 4, 5'b10001,  0);
    tbl[1]  = mk(1,0,0,20,1,0, 4, 5'b10001,  0);
    tbl[2]  = mk(0,1,0,20,1,0, 4, 5'b10001,  0);
    tbl[3]  = mk(0,0,1,20,1,0, 1, 5'b11100,  0);
    tbl[4]  = mk(0,0,0,20,1,0, 0, 5'b00000,  0);
    tbl[5]  = mk(1,0,0,20,0,0, 1, 5'b11100, 20);
    tbl[6]  = mk(0,0,0, 0,0,0, 2, 5'b10000, 20);
    tbl[7]  = mk(0,0,0, 0,0,0, 3, 5'b00010, 20);
    tbl[8]  = mk(1,0,1, 5,1,1, 1, 5'b11100, 20);
    tbl[9]  = mk(0,0,0, 0,0,0, 0, 5'b00000, 20);
    tbl[10] = mk(1,0,0,24,1,0, 4, 5'b10001, 24);
    tbl[11] = mk(0,0,1, 0,0,0, 1, 5'b11100, 24);
    tbl[12] = mk(0,0,0, 0,0,0, 0, 5'b00000, 24);
    tbl[13] = mk(1,0,0,23,1,0, 1, 5'b11100, 23);
    tbl[14] = mk(0,0,0, 0,0,0, 2, 5'b10000, 23);
    tbl[15] = mk(0,0,0, 0,0,0, 2, 5'b10000, 23);
    tbl[16] = mk(0,0,0, 0,0,0, 2, 5'b10000, 23);
    tbl[17] = mk(0,0,0, 0,0,0, 2, 5'b10000, 23);
    tbl[18] = mk(0,0,0, 0,0,0, 2, 5'b11000, 23);
    tbl[19] = mk(0,0,0, 0,0,0, 2, 5'b10000, 23);
    tbl[20] = mk(0,0,0, 0,0,0, 3, 5'b00010, 23);
    tbl[21] = mk(0,1,0, 0,0,0, 3, 5'b00010, 23);
    tbl[22] = mk(1,0,0, 3,1,1, 1, 5'b11100,  3);
    tbl[23] = mk(0,0,0, 0,0,0, 2, 5'b10000,  3);
    tbl[24] = mk(0,1,0, 0,0,0, 0, 5'b00000,  3);

    reset = 1'b1;
    bus.start = 0; bus.stop = 0; bus.clear = 0;
    bus.sw_divideby = '0; bus.sw_updown = 0; bus.sw_freerun = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset outputs", 64'(dut_vec()), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].dv, tbl[i].up, tbl[i].fr);
      check($sformatf("vec%0d state", i), 64'(bus.state), 64'(tbl[i].e_state));
      check($sformatf("vec%0d ctl", i),
            64'({bus.enable1, bus.enable2, bus.counter_reset, bus.done, bus.err}),
            64'(tbl[i].e_ctl));
      check($sformatf("vec%0d divideby", i), 64'(bus.divideby), 64'(tbl[i].e_div));
    end

    // Bounded up-run to halfmax = 15.
    cycle(1, 0, 0, 20, 1, 0);
    check("up halfmax", 64'(bus.halfmax), 64'd15);
    n_rst = bus.counter_reset; pulses = 0; gaps = 0; last = -1; first = -1;
    cyc = 0; fin_seen = 0;
    while (!fin_seen && cyc < 200) begin
      cycle(0, 0, 0, 20, 1, 0);
      cyc++;
      if (bus.counter_reset) n_rst++;
      if (bus.enable2 && bus.state == 3'd2) begin
        if (last >= 0 && cyc - last != TD) gaps++;
        if (first < 0) first = cyc;
        last = cyc;
        pulses++;
      end
      if (bus.done) fin_seen = 1;
    end
    check("up reached done", 64'(fin_seen), 64'd1);
    check("up first tick", 64'(first), 64'(TD + 1));
    check("up tick pulses", 64'(pulses), 64'd15);
    check("up tick spacing", 64'(gaps), 64'd0);
    check("up reset pulses", 64'(n_rst), 64'd1);
    check("up count at done", 64'(bus.count), 64'd15);
    check("up enable1 at done", 64'(bus.enable1), 64'd0);
    cycle(0, 0, 0, 0, 0, 0);

    // Free-run up never completes; stop holds the count.
    cycle(1, 0, 0, 1, 1, 1);
    pulses = 0; gaps = 0; last = -1; done_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      cycle(0, 0, 0, 1, 1, 1);
      if (bus.done) done_seen = 1;
      if (bus.enable2 && bus.state == 3'd2) begin
        if (last >= 0 && c - last != TD) gaps++;
        last = c;
        pulses++;
      end
    end
    check("free tick pulses", 64'(pulses), 64'd9);
    check("free tick spacing", 64'(gaps), 64'd0);
    check("free never done", 64'(done_seen), 64'd0);
    cycle(0, 1, 0, 0, 0, 0);
    check("free stop state", 64'(bus.state), 64'd0);
    check("free stop enable1", 64'(bus.enable1), 64'd0);
    held = bus.count;
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    check("free held count", 64'(bus.count), 64'(held));
    check("free count value", 64'(bus.count), 64'd9);

    // Asynchronous reset in the middle of a tick cycle.
    cycle(1, 0, 0, 1, 1, 1);
    repeat (5) cycle(0, 0, 0, 1, 1, 1);
    check("pre-reset enable2", 64'(bus.enable2), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset outputs", 64'(dut_vec()), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Random pulses and switches against the model.
    for (int i = 0; i < 600; i++) begin
      bit st, sp, cl, up, fr;
      logic [DW-1:0] dv;
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 39) == 0);
      up = 1'($urandom_range(0, 1));
      fr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) dv = DW'($urandom_range(0, 63));
      else                           dv = DW'($urandom_range(18, 25));
      cycle(st, sp, cl, dv, up, fr);
    end
    cycle(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
